// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: FSM state type, widths and branch-table contents.
package fetch_unit_pkg;

  localparam int unsigned PC_W      = 10;
  localparam int unsigned LUT_DEPTH = 32;
  localparam int unsigned LUT_IDX_W = $clog2(LUT_DEPTH);
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Entries 0..3 are fixed targets; the rest follow a regular stride of 8 from 64.
  function automatic logic [15:0] lut_entry(input logic [LUT_IDX_W-1:0] idx);
    logic [15:0] v;
    case (idx)
      5'd0:    v = 16'd0;
      5'd1:    v = 16'd20;
      5'd2:    v = 16'd30;
      5'd3:    v = 16'd40;
      default: v = 16'd64 + (16'(idx) * 16'd8);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Combinational branch-target table: index in, D-bit target address out.
module jump_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned D = PC_W
) (
  input  logic [LUT_IDX_W-1:0] idx,
  output logic [D-1:0]         addr
);

  always_comb begin
    addr = D'(lut_entry(idx));
  end

endmodule

// File: rtl/fetch_unit.sv
// Program-counter sequencer with IDLE/RUN/DONE control and branch/jump/halt selection.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned D          = PC_W,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic                 branch,
  input  logic                 eq_flag,
  input  logic [LUT_IDX_W-1:0] branch_idx,
  input  logic                 jump,
  input  logic [D-1:0]         jump_target,
  input  logic                 halt,
  output logic [D-1:0]         prog_ctr,
  output logic                 fetch_en,
  output logic [D-1:0]         link_addr,
  output logic                 done,
  output logic [CNT_W-1:0]     instr_count
);

  localparam logic [D-1:0] START_PC = D'(START_ADDR);

  state_e       state_q, state_d;
  logic [D-1:0] pc_q, pc_d;
  logic [D-1:0] lut_addr;

  jump_lut #(.D(D)) u_jump_lut (
    .idx  (branch_idx),
    .addr (lut_addr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
      RUN: begin
        if (halt) begin
          state_d = DONE;
        end else if (jump) begin
          pc_d = jump_target;
        end else if (branch && eq_flag) begin
          pc_d = lut_addr;
        end else begin
          pc_d = pc_q + D'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  always_comb begin
    fetch_en  = (state_q == RUN);
    done      = (state_q == DONE);
    prog_ctr  = pc_q;
    link_addr = pc_q + D'(1);
  end

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear on entry to RUN; every RUN cycle (halt included) retires one instruction.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != RUN && state_d == RUN) begin
      cnt_d = '0;
    end else if (state_q == RUN && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected outputs, a negedge monitor checks them.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, req, branch, eq_flag, jump, halt;
  logic [4:0]  branch_idx;
  logic [9:0]  jump_target;
  logic [9:0]  prog_ctr, link_addr;
  logic        fetch_en, done;
  logic [15:0] instr_count;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  typedef struct {
    string       name;
    logic        fe;
    logic        dn;
    logic [9:0]  pc;
    logic [9:0]  link;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  fetch_unit #(.D(10), .START_ADDR(0)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .branch      (branch),
    .eq_flag     (eq_flag),
    .branch_idx  (branch_idx),
    .jump        (jump),
    .jump_target (jump_target),
    .halt        (halt),
    .prog_ctr    (prog_ctr),
    .fetch_en    (fetch_en),
    .link_addr   (link_addr),
    .done        (done),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expectation describes the outputs visible during the current cycle.
  task automatic expect_now(input string name, input bit fe, input bit dn,
                            input int unsigned pc, input int unsigned cnt);
    exp_t e;
    e.name = name;
    e.fe   = fe;
    e.dn   = dn;
    e.pc   = 10'(pc);
    e.link = 10'((pc + 1) % 1024);
`ifdef INSTR_COUNT_EN
    e.cnt  = 16'(cnt);
`else
    e.cnt  = 16'd0;
`endif
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    req = 0; branch = 0; eq_flag = 0; jump = 0; halt = 0;
    branch_idx = '0; jump_target = '0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".fetch_en"},    fetch_en,    e.fe);
      check({e.name, ".done"},        done,        e.dn);
      check({e.name, ".prog_ctr"},    prog_ctr,    e.pc);
      check({e.name, ".link_addr"},   link_addr,   e.link);
      check({e.name, ".instr_count"}, instr_count, e.cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_ctl();
    reset = 1;
    tick();
    tick();
    reset = 0;
    expect_now("after_reset", 0, 0, 0, 0);
    tick();
    expect_now("idle_hold", 0, 0, 0, 0);
    req = 1;
    tick();
    req = 0;
    expect_now("start_pc0", 1, 0, 0, 0);
    tick();
    expect_now("run_pc1", 1, 0, 1, 1);
    req = 1;
    tick();
    req = 0;
    expect_now("req_ignored_pc2", 1, 0, 2, 2);
    tick();
    expect_now("run_pc3", 1, 0, 3, 3);
    tick();
    expect_now("run_pc4", 1, 0, 4, 4);
    tick();
    expect_now("run_pc5", 1, 0, 5, 5);
    branch = 1; eq_flag = 1; branch_idx = 5'd3;
    tick();
    clear_ctl();
    expect_now("branch_taken", 1, 0, 40, 6);
    jump = 1; jump_target = 10'd5;
    tick();
    clear_ctl();
    expect_now("back_to_pc5", 1, 0, 5, 7);
    branch = 1; eq_flag = 0; branch_idx = 5'd3;
    tick();
    clear_ctl();
    expect_now("branch_not_taken", 1, 0, 6, 8);
    branch = 1; eq_flag = 1; branch_idx = 5'd10;
    tick();
    clear_ctl();
    expect_now("branch_idx10", 1, 0, 144, 9);
    jump = 1; jump_target = 10'd9;
    tick();
    clear_ctl();
    expect_now("jump_pc9_link10", 1, 0, 9, 10);
    jump = 1; jump_target = 10'd200; branch = 1; eq_flag = 1; branch_idx = 5'd3;
    tick();
    clear_ctl();
    expect_now("jump_over_branch", 1, 0, 200, 11);
    jump = 1; jump_target = 10'd12;
    tick();
    clear_ctl();
    expect_now("run_pc12", 1, 0, 12, 12);
    halt = 1; jump = 1; jump_target = 10'd77;
    tick();
    clear_ctl();
    expect_now("halt_done", 0, 1, 12, 13);
    jump = 1; jump_target = 10'd99; branch = 1; eq_flag = 1;
    tick();
    clear_ctl();
    expect_now("done_hold", 0, 1, 12, 13);
    req = 1;
    tick();
    req = 0;
    expect_now("restart_pc0", 1, 0, 0, 0);
    jump = 1; jump_target = 10'd1023;
    tick();
    clear_ctl();
    expect_now("pc1023", 1, 0, 1023, 1);
    tick();
    expect_now("wrap_pc0", 1, 0, 0, 2);
    jump = 1; jump_target = 10'd300;
    tick();
    clear_ctl();
    expect_now("pc300", 1, 0, 300, 3);
    reset = 1; req = 1; halt = 1; jump = 1; jump_target = 10'd55;
    tick();
    reset = 0;
    clear_ctl();
    expect_now("midrun_reset", 0, 0, 0, 0);
    req = 1;
    tick();
    req = 0;
    expect_now("cnt_run1", 1, 0, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      expect_now("cnt_run", 1, 0, i, i);
    end
    halt = 1;
    tick();
    clear_ctl();
    expect_now("cnt_done7", 0, 1, 6, 7);
    for (int k = 0; k < 5 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter D, default 10: program counter width, in bits.
REQ-002 Parameter START_ADDR, default 0: first instruction address after start.
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  1  start request from the testbench or top level.
REQ-006 branch  input  1  Branch control from the decoder.
REQ-007 eq_flag  input  1  ALU zero/equal flag for the current instruction.
REQ-008 branch_idx  input  5  index into the branch-target table.
REQ-009 jump  input  1  Jump control from the decoder (JAL).
REQ-010 jump_target  input  D  absolute jump address (ALU pass of rd1).
REQ-011 halt  input  1  decoded halt instruction.
REQ-012 prog_ctr  output  D  address driven to the instruction ROM.
REQ-013 fetch_en  output  1  high when prog_ctr addresses a live instruction.
REQ-014 link_addr  output  D  prog_ctr+1, modulo 2^D, for the JAL write-back.
REQ-015 done  output  1  program complete.
REQ-016 instr_count  output  16  count of retired instructions.

Function
REQ-017 The state machine SHALL have three states:
- IDLE: fetch_en=0, done=0.
- RUN: fetch_en=1, done=0.
- DONE: fetch_en=0, done=1.
REQ-018 From IDLE with req=1, the next state SHALL be RUN and prog_ctr SHALL be loaded with START_ADDR. Otherwise prog_ctr SHALL hold.
REQ-019 In RUN, the next prog_ctr SHALL be selected by priority:
- halt: hold prog_ctr and go to DONE.
- jump: jump_target.
- branch&eq_flag: jump_lut[branch_idx].
- otherwise: prog_ctr+1.
REQ-020 Control latency SHALL be exactly one cycle: the prog_ctr for cycle n+1 is a function of the inputs in cycle n only.
REQ-021 prog_ctr+1 SHALL wrap from 2^D-1 to 0 with no flag and no stall.
REQ-022 branch=1 with eq_flag=0 SHALL behave as a plain increment.
REQ-023 req SHALL be ignored while in RUN.
REQ-024 In DONE with req=1, the next state SHALL be RUN and prog_ctr SHALL be loaded with START_ADDR (restart). Otherwise the state SHALL remain DONE.
REQ-025 link_addr SHALL be combinational from prog_ctr in every state.
REQ-026 Inputs other than req and reset SHALL be don't-care outside RUN.

Reset
REQ-027 On a reset=1 edge, the block SHALL enter IDLE with prog_ctr=START_ADDR and instr_count=0, from any state.
REQ-028 reset SHALL take priority over req, halt, jump and branch in the same cycle.
REQ-029 After reset the outputs SHALL be: fetch_en=0, done=0, link_addr=START_ADDR+1.

Configuration
REQ-030 When the macro INSTR_COUNT_EN is defined:
- instr_count SHALL increment once per RUN cycle, including the halt cycle.
- instr_count SHALL saturate at 16'hFFFF.
- instr_count SHALL clear on reset and on each IDLE/DONE-to-RUN transition.
REQ-031 When INSTR_COUNT_EN is undefined, instr_count SHALL be tied to 0 and no counter register SHALL be synthesized.

Structure
REQ-032 The shared definitions package SHALL hold:
- the state enum (IDLE, RUN, DONE);
- the PC width constant;
- the branch-table depth constant (32).
REQ-033 The branch-target table SHALL be a separate combinational sub-module jump_lut: 5-bit index in, D-bit address out, contents loaded from a constant table.
REQ-034 Total RTL SHALL be 120-400 lines across fetch_unit and jump_lut.

Verification
REQ-035 Reset then start: reset=1 for 2 cycles, then req=1 for 1 cycle -> prog_ctr=0 and fetch_en=1 on the next cycle, then 1, 2, 3 on the cycles after.
REQ-036 Taken branch: at prog_ctr=5, branch=1, eq_flag=1, branch_idx=3, jump_lut[3]=40 -> prog_ctr=40 next cycle. Repeat with eq_flag=0 -> prog_ctr=6.
REQ-037 Jump versus branch: jump=1, jump_target=200, branch=1, eq_flag=1 in the same cycle -> prog_ctr=200. With prog_ctr=9, link_addr=10 during that cycle.
REQ-038 Halt priority and restart:
- halt=1 and jump=1 at prog_ctr=12 -> DONE, done=1, fetch_en=0, prog_ctr holds 12.
- Then req=1 -> RUN with prog_ctr=0.
REQ-039 Wrap and mid-run reset:
- D=10, prog_ctr=1023 with no control -> prog_ctr=0.
- reset=1 at prog_ctr=300 in RUN -> IDLE with prog_ctr=0 next cycle.
REQ-040 INSTR_COUNT_EN defined, halt on the 7th RUN cycle -> instr_count=7 in DONE. With the macro undefined -> instr_count=0 throughout.
